// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with an occupancy count, programmable
// almost-full/almost-empty thresholds, write acknowledge and read-valid.
// Optional build macro SYNC_FIFO_ERR_EN enables the registered overflow and
// underflow pulses. Without it both ports are tied low and no error logic
// exists.
// Accept decisions use the flags as they stand at the start of the cycle,
// so a full FIFO still accepts a read and an empty FIFO still accepts a write.
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FIFO_WIDTH-1:0]         din,
  input  logic                          wen,
  input  logic                          ren,
  output logic [FIFO_WIDTH-1:0]         dout,
  output logic                          valid,
  output logic                          wr_ack,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, wr_ack_q;
  logic                  wr_acc, rd_acc;

  // Accept decisions; nothing is accepted while reset is asserted.
  assign wr_acc = wen && !full  && !rst;
  assign rd_acc = ren && !empty && !rst;

  // Next-state for pointers, occupancy and read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= rd_acc;
      wr_ack_q <= wr_acc;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // Rejected-request pulses, one cycle after the offending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= wen && full;
      underflow_q <= ren && empty;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign count        = count_q;
  assign dout         = dout_q;
  assign valid        = valid_q;
  assign wr_ack       = wr_ack_q;
  assign full         = (count_q == CW'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the FIFO.
module tb_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         wen, ren;
  logic [W-1:0] dout;
  logic         valid, wr_ack, full, empty, almost_full, almost_empty;
  logic [3:0]   count;
  logic         overflow, underflow;

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .din(din), .wen(wen), .ren(ren),
    .dout(dout), .valid(valid), .wr_ack(wr_ack), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  bit m_valid, m_ack, m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, using the occupancy seen before the edge.
  task automatic model_step(input bit w, input bit r, input bit rs, input logic [W-1:0] d);
    bit was_full, was_empty, wa, ra;
    if (rs) begin
      q.delete();
      m_dout = '0; m_valid = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      wa = w && !was_full;
      ra = r && !was_empty;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      m_valid = ra;
      m_ack   = wa;
      m_ovf   = ERR && w && was_full;
      m_unf   = ERR && r && was_empty;
    end
  endtask

  task automatic cyc(input bit w, input bit r, input bit rs, input logic [W-1:0] d);
    wen = w; ren = r; rst = rs; din = d;
    @(posedge clk);
    model_step(w, r, rs, d);
    @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",        32'(count),        32'(q.size()));
      chk("empty",        32'(empty),        32'(q.size() == 0));
      chk("full",         32'(full),         32'(q.size() == D));
      chk("almost_full",  32'(almost_full),  32'(q.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      chk("valid",        32'(valid),        32'(m_valid));
      chk("dout",         32'(dout),         32'(m_dout));
      chk("wr_ack",       32'(wr_ack),       32'(m_ack));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_unf));
    end
  end

  initial begin
    logic [W-1:0] v;
    wen = 0; ren = 0; rst = 1; din = '0;

    // Reset
    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 1, 8'h00);
    chk_en = 1'b1;
    chk("rst_count",  32'(count), 32'd0);
    chk("rst_empty",  32'(empty), 32'd1);
    chk("rst_ae",     32'(almost_empty), 32'd1);
    chk("rst_full",   32'(full), 32'd0);
    chk("rst_dout",   32'(dout), 32'd0);
    chk("rst_valid",  32'(valid), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);

    // Fill
    for (int i = 0; i < 8; i++) begin
      v = 8'h10 + 8'(i);
      cyc(1, 0, 0, v);
      chk("fill_ack", 32'(wr_ack), 32'd1);
      chk("fill_af",  32'(almost_full), (i >= 5) ? 32'd1 : 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    cyc(1, 0, 0, 8'h99);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_ack",   32'(wr_ack), 32'd0);
    chk("ovf_pulse", 32'(overflow), ERR ? 32'd1 : 32'd0);

    // Drain
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 8'h00);
      chk("drain_dout",  32'(dout), 32'h10 + 32'(i));
      chk("drain_valid", 32'(valid), 32'd1);
      chk("drain_ae",    32'(almost_empty), (i >= 5) ? 32'd1 : 32'd0);
    end
    cyc(0, 1, 0, 8'h00);
    chk("unf_dout",  32'(dout), 32'h17);
    chk("unf_valid", 32'(valid), 32'd0);
    chk("unf_empty", 32'(empty), 32'd1);
    chk("unf_pulse", 32'(underflow), ERR ? 32'd1 : 32'd0);

    // Simultaneous read/write at count 4, across pointer wrap
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 8'h30 + 8'(i));
      chk("sim_count", 32'(count), 32'd4);
      chk("sim_dout",  32'(dout), (i < 4) ? 32'h20 + 32'(i) : 32'h30 + 32'(i - 4));
    end
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h40 + 8'(i));
    cyc(1, 1, 0, 8'h55);
    chk("full_rw_count", 32'(count), 32'd7);
    chk("full_rw_ack",   32'(wr_ack), 32'd0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'h66);
    chk("empty_rw_count", 32'(count), 32'd1);
    chk("empty_rw_valid", 32'(valid), 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h70 + 8'(i));
    chk("pre_rst_count", 32'(count), 32'd5);
    cyc(0, 0, 1, 8'h00);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    cyc(0, 1, 0, 8'h00);
    chk("post_rst_valid", 32'(valid), 32'd0);
    cyc(1, 0, 0, 8'hAB);
    cyc(0, 1, 0, 8'h00);
    chk("post_rst_dout", 32'(dout), 32'hAB);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) < 55), ($urandom_range(99) < 50),
          ($urandom_range(199) == 0), 8'($urandom));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
